// File: rtl/rr_mux4_1.sv
// Four-channel round-robin burst multiplexer with a single registered output stage.
// Once a channel wins with last=0 it keeps the grant until its last beat is accepted.
module rr_mux4_1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    input  logic [3:0]         in_last,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [1:0]         r_cur;
    logic [1:0]         w_cur_nxt;

    logic [WIDTH-1:0]   r_out_data;
    logic [1:0]         r_out_sel;
    logic               r_out_last;
    logic               r_out_valid;

    logic               w_load_en;
    logic [1:0]         w_gnt;
    logic               w_gnt_vld;
    logic [1:0]         w_idx;
    logic               w_fire;
    logic [WIDTH-1:0]   w_ch_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_split
        assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign w_load_en = !r_out_valid || out_ready;

    // IDLE: first valid channel starting at ptr; BURST: only the locked channel.
    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_idx     = '0;
        if (r_state == ST_BURST) begin
            w_gnt     = r_cur;
            w_gnt_vld = in_valid[r_cur];
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                w_idx = r_ptr + 2'(k);
                if (!w_gnt_vld && in_valid[w_idx]) begin
                    w_gnt     = w_idx;
                    w_gnt_vld = 1'b1;
                end
            end
        end
    end

    // rst gates the handshake so nothing looks accepted while reset is held.
    assign w_fire   = w_gnt_vld && w_load_en && !rst;
    assign in_ready = w_fire ? (4'b0001 << w_gnt) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cur_nxt   = r_cur;
        if (w_fire) begin
            if (in_last[w_gnt]) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = w_gnt + 2'd1;
            end else begin
                w_state_nxt = ST_BURST;
                w_cur_nxt   = w_gnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load_en) begin
            r_out_valid <= w_fire;
            if (w_fire) begin
                r_out_data <= w_ch_data[w_gnt];
                r_out_sel  <= w_gnt;
                r_out_last <= in_last[w_gnt];
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux4_1.sv
// Directed bench for rr_mux4_1: fairness, burst lock, backpressure, burst gaps,
// reset mid-burst and idle behaviour, all against hand-computed expectations.
module tb_rr_mux4_1;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_valid;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    int n_cmp = 0;
    int n_err = 0;

    rr_mux4_1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int unsigned ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 4'b0000);
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_sel", out_sel, 2'd0);
        check("rst_out_last", out_last, 1'b0);

        // Fairness: all channels valid, single-beat bursts.
        for (int unsigned i = 0; i < 4; i++) set_ch(i, 8'h10 + 8'(i));
        rst = 1'b0;
        #1;
        check("fair_first_ready", in_ready, 4'b0001);
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            check("fair_sel", out_sel, 2'(k % 4));
            check("fair_data", out_data, 8'h10 + 8'(k % 4));
            check("fair_valid", out_valid, 1'b1);
        end

        // Burst lock: move ptr to 2 with a ch1 single beat, then ch2 bursts while ch0 waits.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        in_last   = 4'b0010;
        set_ch(1, 8'h31);
        tick();
        check("lock_pre_sel", out_sel, 2'd1);
        in_valid = 4'b0101;
        in_last  = 4'b0001;
        set_ch(0, 8'hC0);
        for (int unsigned b = 0; b < 3; b++) begin
            set_ch(2, 8'hA0 + 8'(b));
            if (b == 2) in_last = 4'b0101;
            #1;
            check("lock_ready", in_ready, 4'b0100);
            tick();
            check("lock_sel", out_sel, 2'd2);
            check("lock_data", out_data, 8'hA0 + 8'(b));
            check("lock_last", out_last, (b == 2) ? 1'b1 : 1'b0);
        end
        in_valid = 4'b0001;
        #1;
        check("lock_after_ready", in_ready, 4'b0001);
        tick();
        check("lock_after_sel", out_sel, 2'd0);
        check("lock_after_data", out_data, 8'hC0);

        // Backpressure: hold A5 for five cycles with out_ready low.
        do_reset();
        in_valid = 4'b0001;
        in_last  = 4'b0011;
        set_ch(0, 8'hA5);
        tick();
        check("bp_load_data", out_data, 8'hA5);
        in_valid = 4'b0010;
        set_ch(1, 8'h5A);
        for (int unsigned c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", in_ready, 4'b0000);
            tick();
            check("bp_hold_data", out_data, 8'hA5);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 4'b0010);
        tick();
        check("bp_next_data", out_data, 8'h5A);
        check("bp_next_sel", out_sel, 2'd1);

        // Burst gap: ch1 locked, ch3 must not sneak in while ch1 is idle.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1010;
        in_last   = 4'b1000;
        set_ch(1, 8'h61);
        set_ch(3, 8'h63);
        #1;
        check("gap_first_ready", in_ready, 4'b0010);
        tick();
        check("gap_first_sel", out_sel, 2'd1);
        in_valid = 4'b1000;
        for (int unsigned c = 0; c < 3; c++) begin
            #1;
            check("gap_ready", in_ready, 4'b0000);
            tick();
            check("gap_valid", out_valid, 1'b0);
        end
        in_valid = 4'b1010;
        in_last  = 4'b1010;
        set_ch(1, 8'h62);
        #1;
        check("gap_resume_ready", in_ready, 4'b0010);
        tick();
        check("gap_end_sel", out_sel, 2'd1);
        check("gap_end_last", out_last, 1'b1);
        check("gap_end_data", out_data, 8'h62);
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        #1;
        check("gap_ptr2_ready", in_ready, 4'b0100);
        tick();
        check("gap_ptr2_sel", out_sel, 2'd2);

        // Reset mid-burst with a pending output beat.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        in_last   = 4'b0000;
        set_ch(3, 8'h73);
        tick();
        check("mid_sel", out_sel, 2'd3);
        tick();
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid_async", out_valid, 1'b0);
        check("mid_sel_async", out_sel, 2'd0);
        check("mid_ready", in_ready, 4'b0000);
        #1;
        rst       = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("mid_post_ready", in_ready, 4'b0001);
        tick();
        check("mid_post_sel", out_sel, 2'd0);

        // Idle: nothing valid for ten cycles, ptr stays at 1.
        in_valid = 4'b0000;
        for (int unsigned c = 0; c < 10; c++) begin
            tick();
            check("idle_valid", out_valid, 1'b0);
            check("idle_ready", in_ready, 4'b0000);
        end
        in_valid = 4'b1111;
        #1;
        check("idle_ptr_ready", in_ready, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
